store_unit: RTL

//   Store-side counterpart of the load sign/zero-extension path: accepts one RV64I store (SB/SH/SW/SD)
//   and drives it onto the 64-bit data-memory write port as byte-lane-aligned data plus byte strobes.
//   A store crossing an 8-byte boundary is split into two bus beats. It sits between the execute/MEM

---
 rtl/store_unit_pkg.sv | 39 +++
 rtl/store_lane_align.sv | 42 ++++
 rtl/store_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_unit_pkg
//  Description : Shared types and helpers for the RV64I store path.
//                store_size_e : SB/SH/SW/SD encoding of funct3[1:0]
//                size_mask    : byte mask of the low (1<<size) bytes
//                crosses_dword: store at byte offset off spills past byte 7
//  Revision    : 1.0 - initial release
// ============================================================================
package store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } store_size_e;

    // Byte mask covering the low 1<<size bytes of a dword.
    function automatic logic [7:0] size_mask(input store_size_e size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // True when off + nbytes exceeds 8, i.e. the access touches the next dword.
    function automatic logic crosses_dword(input logic [2:0] off, input store_size_e size);
        logic [3:0] end_byte;
        end_byte = {1'b0, off} + (4'd1 << size);
        return (end_byte > 4'd8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_align
//  Description : Combinational lane aligner. Places the low (1<<size) bytes
//                of data at byte offset off inside a 16-byte window and
//                produces the matching 16-bit strobe.
//  Ports       : off     in  3    byte offset inside the first dword
//                size    in  2    store size (store_size_e)
//                data    in  64   rs2 value
//                data128 out 128  aligned data, unused bytes zero
//                strb16  out 16   byte enables for data128
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
    import store_unit_pkg::*;
(
    input  logic [2:0]   off,
    input  store_size_e  size,
    input  logic [63:0]  data,
    output logic [127:0] data128,
    output logic [15:0]  strb16
);

    logic [7:0]  mask;
    logic [63:0] byte_mask;
    logic [63:0] data_kept;

    assign mask = size_mask(size);

    generate
        for (genvar i = 0; i < 8; i++) begin : g_byte_mask
            assign byte_mask[8*i +: 8] = {8{mask[i]}};
        end
    endgenerate

    // Bytes above the store size are cleared so unused lanes stay zero.
    assign data_kept = data & byte_mask;
    assign data128   = {64'd0, data_kept} << {off, 3'b000};
    assign strb16    = {8'd0, mask} << off;

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_unit
//  Description : Accepts one RV64I store (SB/SH/SW/SD) and drives it onto a
//                64-bit write port as lane-aligned data with byte strobes.
//                Stores crossing an 8-byte boundary are issued as two beats
//                (SPLIT_EN=1) or rejected with resp_err (SPLIT_EN=0).
//  Ports       : clk, rst                   clock / async active-high reset
//                req_valid/ready/addr/data/size   store request
//                mem_wvalid/wready/waddr/wdata/wstrb  memory write beat
//                resp_valid, resp_err       completion pulse and error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter bit          SPLIT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wstrb,
    output logic                  resp_valid,
    output logic                  resp_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    store_size_e           size_q;
    logic                  err_q;

    logic                  req_cross;
    logic [ADDR_WIDTH-1:0] beat0_addr;
    logic [127:0]          data128;
    logic [15:0]           strb16;

    // Decided on the live request so a rejected store never reaches a beat state.
    assign req_cross  = crosses_dword(req_addr[2:0], store_size_e'(req_size));
    assign beat0_addr = {addr_q[ADDR_WIDTH-1:3], 3'b000};

    store_lane_align u_align (
        .off     (addr_q[2:0]),
        .size    (size_q),
        .data    (data_q),
        .data128 (data128),
        .strb16  (strb16)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= SZ_B;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        size_q <= store_size_e'(req_size);
                        if (req_cross && !SPLIT_EN) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_wready) begin
                        state <= (|strb16[15:8]) ? ST_BEAT1 : ST_RESP;
                    end
                end
                ST_BEAT1: begin
                    if (mem_wready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload is a pure function of state and the latched request, so it is
    // inherently stable while a beat waits for mem_wready.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_BEAT0: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beat0_addr;
                mem_wdata  = data128[63:0];
                mem_wstrb  = strb16[7:0];
            end
            ST_BEAT1: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beat0_addr + ADDR_WIDTH'(8);
                mem_wdata  = data128[127:64];
                mem_wstrb  = strb16[15:8];
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
